// File: rtl/regfile_writeback_if.sv
// Bundle of the producer channels, flush, register-file write port and status
// outputs of regfile_writeback. The master side produces results; the slave is the block.
interface regfile_writeback_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          alu_valid;
  logic          alu_ready;
  logic [AW-1:0] alu_wta;
  logic [DW-1:0] alu_wtd;
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_wta;
  logic [DW-1:0] mem_wtd;
  logic          flush;
  logic [AW-1:0] wta;
  logic [DW-1:0] wtd;
  logic          cnt;
  logic [31:0]   pend_mask;
  logic [CW-1:0] count;

  modport master (
    output alu_valid, alu_wta, alu_wtd,
    output mem_valid, mem_wta, mem_wtd,
    output flush,
    input  alu_ready, mem_ready,
    input  wta, wtd, cnt, pend_mask, count
  );

  modport slave (
    input  alu_valid, alu_wta, alu_wtd,
    input  mem_valid, mem_wta, mem_wtd,
    input  flush,
    output alu_ready, mem_ready,
    output wta, wtd, cnt, pend_mask, count
  );
endinterface

// File: rtl/regfile_writeback.sv
// In-order write-back queue feeding the register-file write port, with an empty-queue
// bypass and a pending-write scoreboard for RAW hazard stalls in decode.
module regfile_writeback #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  regfile_writeback_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [AW-1:0] wta;
    logic [DW-1:0] wtd;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  entry_t        out_q,    out_d;
  logic          cnt_q,    cnt_d;

  logic [CW-1:0] free;
  logic          mem_ready, alu_ready;
  logic          mem_keep, alu_keep;
  logic          empty;
  entry_t        arr [2];
  logic [1:0]    n_arr;
  logic          push0, push1;
  entry_t        push_data0, push_data1;
  logic [31:0]   pend_d;

  // Ready looks only at registered occupancy, so a pop never frees a slot early.
  assign free      = CW'(DEPTH) - count_q;
  assign mem_ready = (free != '0);
  assign alu_ready = (free >= CW'(2)) || ((free != '0) && !bus.mem_valid);

  // Writes to x0 are accepted on the handshake but never queued or driven.
  assign mem_keep = bus.mem_valid && mem_ready && (bus.mem_wta != '0);
  assign alu_keep = bus.alu_valid && alu_ready && (bus.alu_wta != '0);
  assign empty    = (count_q == '0);

  // Arrivals in age order: MEM is older than ALU when both land together.
  // NOTE: every variable assigned in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    arr[0] = '{wta: bus.mem_wta, wtd: bus.mem_wtd};
    arr[1] = '{wta: bus.alu_wta, wtd: bus.alu_wtd};
    n_arr  = 2'd0;
    if (mem_keep && alu_keep) begin
      n_arr = 2'd2;
    end else if (mem_keep) begin
      n_arr = 2'd1;
    end else if (alu_keep) begin
      arr[0] = '{wta: bus.alu_wta, wtd: bus.alu_wtd};
      n_arr  = 2'd1;
    end
  end

  always_comb begin
    out_d      = out_q;
    cnt_d      = 1'b0;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    push0      = 1'b0;
    push1      = 1'b0;
    push_data0 = arr[0];
    push_data1 = arr[1];

    if (bus.flush) begin
      // The write already on the port completes at this edge; queue and arrivals are dropped.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (!empty) begin
        out_d    = mem_q[rd_ptr_q];
        cnt_d    = 1'b1;
        rd_ptr_d = rd_ptr_q + PW'(1);
        push0    = (n_arr != 2'd0);
        push1    = (n_arr == 2'd2);
      end else if (n_arr != 2'd0) begin
        // Empty queue: the oldest arrival goes straight to the port, a second one queues.
        out_d      = arr[0];
        cnt_d      = 1'b1;
        push0      = (n_arr == 2'd2);
        push_data0 = arr[1];
      end
      wr_ptr_d = wr_ptr_q + PW'(push0) + PW'(push1);
      count_d  = count_q + CW'(push0) + CW'(push1) - CW'(!empty);
    end
  end

  // NOTE: queue storage has no reset; occupancy is tracked by count/pointers, so stale slots are never read.
  always_ff @(posedge clk) begin
    if (push0) mem_q[wr_ptr_q] <= push_data0;
    if (push1) mem_q[wr_ptr_q + PW'(1)] <= push_data1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      out_q    <= '0;
      cnt_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      out_q    <= out_d;
      cnt_q    <= cnt_d;
    end
  end

  // Scoreboard: a slot is live when its distance from the read pointer is below count.
  always_comb begin
    pend_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ({1'b0, PW'(PW'(i) - rd_ptr_q)} < count_q) begin
        pend_d[mem_q[i].wta] = 1'b1;
      end
    end
    if (cnt_q) pend_d[out_q.wta] = 1'b1;
  end

  assign bus.alu_ready = alu_ready;
  assign bus.mem_ready = mem_ready;
  assign bus.wta       = out_q.wta;
  assign bus.wtd       = out_q.wtd;
  assign bus.cnt       = cnt_q;
  assign bus.count     = count_q;
  assign bus.pend_mask = pend_d;

endmodule
